// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, programmable almost flags, flush,
// and selectable standard or first-word-fall-through read mode.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       rvalid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       wr_error_o,
    output logic                       rd_error_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_wr_err;
    logic             r_rd_err;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W-1:0] w_count_nxt;

    // Flags come only from the registered count.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // Flush wins over any request issued in the same cycle.
    assign w_pop  = rd_en_i & ~w_empty & ~clr_i;
    assign w_push = wr_en_i & ~clr_i & (~w_full | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count  <= w_count_nxt;
            r_wr_err <= wr_en_i & ~w_push;
            r_rd_err <= rd_en_i & ~w_pop;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue shown directly; forced to zero while empty.
            assign rdata_o  = w_empty ? '0 : r_mem[r_rd_ptr];
            assign rvalid_o = ~w_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_rdata;
            logic             r_rvalid;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_pop;
                    if (w_pop) begin
                        r_rdata <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign rdata_o  = r_rdata;
            assign rvalid_o = r_rvalid;
        end
    endgenerate

    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (r_count >= AF_C);
    assign almost_empty_o = (r_count <= AE_C);
    assign count_o        = r_count;
    assign wr_error_o     = r_wr_err;
    assign rd_error_o     = r_rd_err;

endmodule
